// File: rtl/timer_chain_reader.sv
// Master end of the timer daisy-chain: drives data_clock, samples the chain's serial
// output and presents one {enabled, timestamp} record per timer on a valid/ready port.
module timer_chain_reader #(
  parameter int NUM_TIMERS  = 4,
  parameter int HALF_PERIOD = 8,
  parameter int IDX_W       = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             data_clock,
  output logic             data_shiftin,
  input  logic             data_shiftout,
  output logic [31:0]      word_data,
  output logic             word_enabled,
  output logic             word_triggered,
  output logic [IDX_W-1:0] word_index,
  output logic             word_valid,
  input  logic             word_ready
);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    PRESENT
  } state_t;

  localparam int               PH_W      = $clog2(HALF_PERIOD);
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(HALF_PERIOD - 1);
  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(NUM_TIMERS - 1);
  localparam logic [5:0]       LAST_BIT  = 6'd32;
  localparam logic [31:0]      NO_TRIG   = 32'hFFFF_FFFE;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [5:0]       bit_q, bit_d;
  logic [IDX_W-1:0] wrd_q, wrd_d;
  logic [32:0]      sr_q, sr_d;
  logic             dclk_q, dclk_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      wrd_q   <= '0;
      sr_q    <= '0;
      dclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      wrd_q   <= wrd_d;
      sr_q    <= sr_d;
      dclk_q  <= dclk_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    wrd_d   = wrd_q;
    sr_d    = sr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bit_d   = '0;
          wrd_d   = '0;
          ph_d    = '0;
          state_d = LOW;
        end
      end
      LOW: begin
        // Sample on the last LOW cycle: as late as possible after the previous rising edge.
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          sr_d = {data_shiftout, sr_q[32:1]};
          if (bit_q == LAST_BIT) begin
            state_d = PRESENT;
          end else begin
            bit_d   = bit_q + 6'd1;
            state_d = HIGH;
          end
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      HIGH: begin
        if (ph_q == PH_LAST) begin
          ph_d    = '0;
          state_d = LOW;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      PRESENT: begin
        // The final record skips the HIGH phase, so no rising edge follows its last bit.
        if (word_ready) begin
          if (wrd_q == LAST_WORD) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            wrd_d   = wrd_q + IDX_W'(1);
            bit_d   = '0;
            ph_d    = '0;
            state_d = HIGH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    dclk_d = (state_d == HIGH);
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign data_clock     = dclk_q;
  assign data_shiftin   = 1'b0;
  assign word_valid     = (state_q == PRESENT);
  assign word_data      = sr_q[32:1];
  assign word_enabled   = sr_q[0];
  assign word_triggered = (sr_q[32:1] != NO_TRIG);
  assign word_index     = wrd_q;

endmodule

// File: tb/tb_timer_chain_reader.sv
// Bench for timer_chain_reader: three readers (3 timers/H=4, 1 timer/H=4, 1 timer/H=16),
// each fed by a behavioural timer-chain model with a 2-flop synchroniser and edge detect.
module tb_timer_chain_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic load = 1'b0;
  logic clr_edges = 1'b0;
  int   sel = 0;
  logic [98:0] load_val = '0;

  int checks = 0;
  int errors = 0;

  logic start_a, start_b, start_c;
  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign start_c = start && (sel == 2);

  logic busy_a, done_a, dc_a, dsi_a, dso_a, en_a, trig_a, valid_a;
  logic busy_b, done_b, dc_b, dsi_b, dso_b, en_b, trig_b, valid_b;
  logic busy_c, done_c, dc_c, dsi_c, dso_c, en_c, trig_c, valid_c;
  logic [31:0] data_a, data_b, data_c;
  logic [1:0]  idx_a;
  logic [0:0]  idx_b, idx_c;

  timer_chain_reader #(.NUM_TIMERS(3), .HALF_PERIOD(4)) u_a (
    .clk(clk), .reset(reset_n), .start(start_a), .busy(busy_a), .done(done_a),
    .data_clock(dc_a), .data_shiftin(dsi_a), .data_shiftout(dso_a),
    .word_data(data_a), .word_enabled(en_a), .word_triggered(trig_a),
    .word_index(idx_a), .word_valid(valid_a), .word_ready(ready));

  timer_chain_reader #(.NUM_TIMERS(1), .HALF_PERIOD(4)) u_b (
    .clk(clk), .reset(reset_n), .start(start_b), .busy(busy_b), .done(done_b),
    .data_clock(dc_b), .data_shiftin(dsi_b), .data_shiftout(dso_b),
    .word_data(data_b), .word_enabled(en_b), .word_triggered(trig_b),
    .word_index(idx_b), .word_valid(valid_b), .word_ready(ready));

  timer_chain_reader #(.NUM_TIMERS(1), .HALF_PERIOD(16)) u_c (
    .clk(clk), .reset(reset_n), .start(start_c), .busy(busy_c), .done(done_c),
    .data_clock(dc_c), .data_shiftin(dsi_c), .data_shiftout(dso_c),
    .word_data(data_c), .word_enabled(en_c), .word_triggered(trig_c),
    .word_index(idx_c), .word_valid(valid_c), .word_ready(ready));

  // Timer chain models: bit 0 is what the last timer presents to the reader.
  logic [98:0] ch_a = '0;
  logic [32:0] ch_b = '0, ch_c = '0;
  logic [2:0]  sy_a = '0, sy_b = '0, sy_c = '0;
  logic        pa = 1'b0, pb = 1'b0, pc = 1'b0;
  int          edges_a = 0, edges_b = 0, edges_c = 0;

  assign dso_a = ch_a[0];
  assign dso_b = ch_b[0];
  assign dso_c = ch_c[0];

  always @(posedge clk) begin
    sy_a <= {sy_a[1:0], dc_a};
    sy_b <= {sy_b[1:0], dc_b};
    sy_c <= {sy_c[1:0], dc_c};
    if (load && sel == 0) ch_a <= load_val;
    else if (sy_a[1] && !sy_a[2]) ch_a <= {dsi_a, ch_a[98:1]};
    if (load && sel == 1) ch_b <= load_val[32:0];
    else if (sy_b[1] && !sy_b[2]) ch_b <= {dsi_b, ch_b[32:1]};
    if (load && sel == 2) ch_c <= load_val[32:0];
    else if (sy_c[1] && !sy_c[2]) ch_c <= {dsi_c, ch_c[32:1]};
    pa <= dc_a;
    pb <= dc_b;
    pc <= dc_c;
    if (clr_edges) begin
      edges_a <= 0;
      edges_b <= 0;
      edges_c <= 0;
    end else begin
      if (dc_a && !pa) edges_a <= edges_a + 1;
      if (dc_b && !pb) edges_b <= edges_b + 1;
      if (dc_c && !pc) edges_c <= edges_c + 1;
    end
  end

  logic        c_valid, c_en, c_trig, c_done, c_busy, c_dc, c_dsi;
  logic [31:0] c_data, c_idx;
  int          c_edges;

  always_comb begin
    c_valid = valid_c; c_data = data_c; c_en = en_c; c_trig = trig_c; c_idx = 32'(idx_c);
    c_done = done_c; c_busy = busy_c; c_dc = dc_c; c_dsi = dsi_c; c_edges = edges_c;
    if (sel == 0) begin
      c_valid = valid_a; c_data = data_a; c_en = en_a; c_trig = trig_a; c_idx = 32'(idx_a);
      c_done = done_a; c_busy = busy_a; c_dc = dc_a; c_dsi = dsi_a; c_edges = edges_a;
    end else if (sel == 1) begin
      c_valid = valid_b; c_data = data_b; c_en = en_b; c_trig = trig_b; c_idx = 32'(idx_b);
      c_done = done_b; c_busy = busy_b; c_dc = dc_b; c_dsi = dsi_b; c_edges = edges_b;
    end
  end

  // Reference timer contents: tdat[0] is the first timer in the chain (farthest from reader).
  logic [31:0] tdat [3];
  logic        ten  [3];

  logic [31:0] o_data [8];
  logic        o_en   [8];
  logic        o_trig [8];
  logic [31:0] o_idx  [8];
  int o_cnt, first_lat, done_lat, done_cnt, unstable, timeout, o_edges, rst_done, quiet_bad;
  logic done_busy;
  logic r_dc, r_busy, r_done, r_valid, r_en;
  logic [31:0] r_data, r_idx;

  function automatic int n_of(input int s);
    return (s == 0) ? 3 : 1;
  endfunction

  function automatic int h_of(input int s);
    return (s == 2) ? 16 : 4;
  endfunction

  task automatic arm();
    int n;
    n = n_of(sel);
    load_val = '0;
    for (int k = 0; k < n; k++) load_val[33*k +: 33] = {tdat[n-1-k], ten[n-1-k]};
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Runs one readout on the selected reader and records what it observed.
  task automatic do_readout(input int stall, input bit inj, input int rst_edge);
    int cyc, limit;
    bit adv;
    logic [31:0] rd, ri;
    logic re;
    limit = n_of(sel) * (66 * h_of(sel) + 1 + stall) + 100;
    o_cnt = 0; first_lat = -1; done_lat = -1; done_cnt = 0; unstable = 0;
    timeout = 0; rst_done = 0; quiet_bad = 0; done_busy = 1'bx;
    @(negedge clk);
    clr_edges = 1'b1; start = 1'b1; ready = (stall == 0);
    @(negedge clk);
    clr_edges = 1'b0; start = 1'b0; cyc = 1;
    forever begin
      adv = 1'b1;
      start = inj && (cyc == 100);
      if (c_done === 1'b1) begin
        done_cnt++;
        if (done_lat < 0) begin done_lat = cyc; done_busy = c_busy; end
      end
      if (done_lat >= 0) break;
      if (cyc >= limit) begin timeout = 1; break; end
      if (rst_edge > 0 && c_edges >= rst_edge && c_dc === 1'b1) begin
        reset_n = 1'b0; start = 1'b0;
        @(negedge clk);
        r_dc = c_dc; r_busy = c_busy; r_done = c_done; r_valid = c_valid;
        r_data = c_data; r_en = c_en; r_idx = c_idx;
        reset_n = 1'b1;
        rst_done = 1;
        for (int i = 0; i < 300; i++) begin
          @(negedge clk);
          if (c_done !== 1'b0 || c_busy !== 1'b0 || c_dc !== 1'b0 || c_valid !== 1'b0) quiet_bad++;
        end
        break;
      end
      if (c_valid === 1'b1) begin
        if (first_lat < 0) first_lat = cyc;
        rd = c_data; re = c_en; ri = c_idx;
        if (o_cnt < 8) begin
          o_data[o_cnt] = c_data; o_en[o_cnt] = c_en; o_trig[o_cnt] = c_trig; o_idx[o_cnt] = c_idx;
        end
        if (stall > 0) begin
          for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            cyc++;
            if (c_valid !== 1'b1 || c_data !== rd || c_en !== re || c_idx !== ri || c_dc !== 1'b0)
              unstable++;
          end
          ready = 1'b1;
          @(negedge clk);
          cyc++;
          ready = 1'b0;
          adv = 1'b0;
        end
        o_cnt++;
      end
      if (adv) begin
        @(negedge clk);
        cyc++;
      end
    end
    o_edges = c_edges;
    start = 1'b0;
    ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if ({c_dc, c_busy, c_done, c_valid, c_en, c_dsi} !== 6'b0) begin
        errors++;
        $display("FAIL reset_ctrl[%0d]: got %b want 000000", s, {c_dc, c_busy, c_done, c_valid, c_en, c_dsi});
      end
      checks++;
      if (c_data !== 32'h0 || c_idx !== 32'h0) begin
        errors++;
        $display("FAIL reset_data[%0d]: got data %h idx %0d want 0 0", s, c_data, c_idx);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_timer();
    sel = 1;
    tdat[0] = 32'h1234_5678; ten[0] = 1'b1;
    arm();
    do_readout(0, 1'b0, 0);
    checks++; if (timeout !== 0) begin errors++; $display("FAIL single_timeout: got %0d want 0", timeout); end
    checks++; if (o_cnt !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", o_cnt); end
    checks++; if ({o_en[0], o_data[0]} !== {1'b1, 32'h1234_5678}) begin errors++;
      $display("FAIL single_record: got %b %h want 1 12345678", o_en[0], o_data[0]); end
    checks++; if (o_idx[0] !== 32'h0 || o_trig[0] !== 1'b1) begin errors++;
      $display("FAIL single_idx_trig: got %0d %b want 0 1", o_idx[0], o_trig[0]); end
    checks++; if (first_lat !== 261) begin errors++; $display("FAIL single_valid_lat: got %0d want 261", first_lat); end
    checks++; if (done_lat !== 262) begin errors++; $display("FAIL single_done_lat: got %0d want 262", done_lat); end
    checks++; if (o_edges !== 32) begin errors++; $display("FAIL single_edges: got %0d want 32", o_edges); end
    checks++; if (done_busy !== 1'b0) begin errors++; $display("FAIL single_busy_at_done: got %b want 0", done_busy); end
  endtask

  task automatic set_mixed();
    tdat[0] = 32'h0000_000A; ten[0] = 1'b1;
    tdat[1] = 32'hFFFF_FFFE; ten[1] = 1'b0;
    tdat[2] = 32'hDEAD_BEEF; ten[2] = 1'b1;
  endtask

  task automatic test_three_mixed();
    logic [31:0] ed [3];
    logic        ee [3];
    logic        et [3];
    ed = '{32'hDEAD_BEEF, 32'hFFFF_FFFE, 32'h0000_000A};
    ee = '{1'b1, 1'b0, 1'b1};
    et = '{1'b1, 1'b0, 1'b1};
    sel = 0;
    set_mixed();
    arm();
    do_readout(0, 1'b0, 0);
    checks++; if (o_cnt !== 3) begin errors++; $display("FAIL mixed_count: got %0d want 3", o_cnt); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_data[k] !== ed[k] || o_en[k] !== ee[k] || o_trig[k] !== et[k] || o_idx[k] !== 32'(k)) begin
        errors++;
        $display("FAIL mixed_rec%0d: got %h en%b trig%b idx%0d want %h en%b trig%b idx%0d",
                 k, o_data[k], o_en[k], o_trig[k], o_idx[k], ed[k], ee[k], et[k], k);
      end
    end
    checks++; if (o_edges !== 98) begin errors++; $display("FAIL mixed_edges: got %0d want 98", o_edges); end
    checks++; if (done_lat !== 792 || done_cnt !== 1) begin errors++;
      $display("FAIL mixed_done: got lat %0d cnt %0d want 792 1", done_lat, done_cnt); end
  endtask

  task automatic test_backpressure();
    logic [31:0] ed [3];
    ed = '{32'hDEAD_BEEF, 32'hFFFF_FFFE, 32'h0000_000A};
    sel = 0;
    set_mixed();
    arm();
    do_readout(50, 1'b0, 0);
    checks++; if (o_cnt !== 3) begin errors++; $display("FAIL bp_count: got %0d want 3", o_cnt); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_data[k] !== ed[k] || o_idx[k] !== 32'(k)) begin
        errors++;
        $display("FAIL bp_rec%0d: got %h idx%0d want %h idx%0d", k, o_data[k], o_idx[k], ed[k], k);
      end
    end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles want 0", unstable); end
    checks++; if (o_edges !== 98) begin errors++; $display("FAIL bp_edges: got %0d want 98", o_edges); end
    checks++; if (done_lat !== 942) begin errors++; $display("FAIL bp_done_lat: got %0d want 942", done_lat); end
  endtask

  task automatic randomize_timers(input int n);
    for (int k = 0; k < n; k++) begin
      tdat[k] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
      ten[k]  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset_mid();
    sel = 0;
    randomize_timers(3);
    arm();
    do_readout(0, 1'b0, 50);
    checks++; if (rst_done !== 1) begin errors++; $display("FAIL rstmid_hit: got %0d want 1", rst_done); end
    checks++; if ({r_dc, r_busy, r_done, r_valid, r_en} !== 5'b0 || r_data !== 32'h0 || r_idx !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: got %b data %h idx %0d want 00000 0 0", {r_dc, r_busy, r_done, r_valid, r_en}, r_data, r_idx);
    end
    checks++; if (done_cnt !== 0 || quiet_bad !== 0) begin errors++;
      $display("FAIL rstmid_quiet: got done %0d activity %0d want 0 0", done_cnt, quiet_bad); end
    checks++; if (o_cnt !== 1 || o_data[0] !== tdat[2]) begin errors++;
      $display("FAIL rstmid_first: got cnt %0d data %h want 1 %h", o_cnt, o_data[0], tdat[2]); end
    randomize_timers(3);
    arm();
    do_readout(0, 1'b0, 0);
    checks++; if (o_cnt !== 3 || done_lat !== 792 || o_edges !== 98) begin errors++;
      $display("FAIL rstmid_rerun: got cnt %0d lat %0d edges %0d want 3 792 98", o_cnt, done_lat, o_edges); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (o_data[k] !== tdat[2-k] || o_en[k] !== ten[2-k]) begin
        errors++;
        $display("FAIL rstmid_rec%0d: got %h en%b want %h en%b", k, o_data[k], o_en[k], tdat[2-k], ten[2-k]);
      end
    end
  endtask

  task automatic test_ignored_start();
    sel = 0;
    set_mixed();
    arm();
    do_readout(0, 1'b1, 0);
    checks++; if (o_edges !== 98) begin errors++; $display("FAIL ign_edges: got %0d want 98", o_edges); end
    checks++; if (done_lat !== 792 || done_cnt !== 1 || o_cnt !== 3) begin errors++;
      $display("FAIL ign_done: got lat %0d done %0d recs %0d want 792 1 3", done_lat, done_cnt, o_cnt); end
    checks++; if (o_data[0] !== 32'hDEAD_BEEF || o_data[2] !== 32'h0000_000A) begin errors++;
      $display("FAIL ign_data: got %h %h want deadbeef 0000000a", o_data[0], o_data[2]); end
  endtask

  task automatic test_latency_h16();
    sel = 2;
    randomize_timers(1);
    arm();
    do_readout(0, 1'b0, 0);
    checks++; if (first_lat !== 1041) begin errors++; $display("FAIL h16_valid_lat: got %0d want 1041", first_lat); end
    checks++; if (done_lat !== 1042) begin errors++; $display("FAIL h16_done_lat: got %0d want 1042", done_lat); end
    checks++; if (o_edges !== 32) begin errors++; $display("FAIL h16_edges: got %0d want 32", o_edges); end
    checks++; if (o_data[0] !== tdat[0] || o_en[0] !== ten[0] || o_trig[0] !== (tdat[0] != 32'hFFFF_FFFE)) begin
      errors++;
      $display("FAIL h16_record: got %h en%b trig%b want %h en%b", o_data[0], o_en[0], o_trig[0], tdat[0], ten[0]);
    end
  endtask

  task automatic test_random();
    int n, h, stall, exp_done;
    for (int it = 0; it < 8; it++) begin
      sel = $urandom_range(0, 2);
      n = n_of(sel);
      h = h_of(sel);
      stall = $urandom_range(0, 4);
      randomize_timers(n);
      arm();
      do_readout(stall, 1'b0, 0);
      exp_done = 65 * h + 1 + (n - 1) * (66 * h + 1) + n * stall + 1;
      checks++; if (timeout !== 0 || o_cnt !== n) begin errors++;
        $display("FAIL rand%0d_count: got to %0d cnt %0d want 0 %0d", it, timeout, o_cnt, n); end
      for (int k = 0; k < n; k++) begin
        checks++;
        if (o_data[k] !== tdat[n-1-k] || o_en[k] !== ten[n-1-k] || o_idx[k] !== 32'(k) ||
            o_trig[k] !== (tdat[n-1-k] != 32'hFFFF_FFFE)) begin
          errors++;
          $display("FAIL rand%0d_rec%0d: got %h en%b idx%0d trig%b want %h en%b idx%0d",
                   it, k, o_data[k], o_en[k], o_idx[k], o_trig[k], tdat[n-1-k], ten[n-1-k], k);
        end
      end
      checks++; if (o_edges !== 33 * n - 1) begin errors++;
        $display("FAIL rand%0d_edges: got %0d want %0d", it, o_edges, 33 * n - 1); end
      checks++; if (done_lat !== exp_done || done_cnt !== 1 || unstable !== 0) begin errors++;
        $display("FAIL rand%0d_timing: got lat %0d done %0d unstable %0d want %0d 1 0",
                 it, done_lat, done_cnt, unstable, exp_done); end
    end
  endtask

  initial begin
    test_reset();
    test_single_timer();
    test_three_mixed();
    test_backpressure();
    test_reset_mid();
    test_ignored_start();
    test_latency_h16();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/timer_chain_reader.md
# timer_chain_reader

Master end of the timer daisy-chain readout. Generates the `data_clock` serial clock for a chain of `NUM_TIMERS` trigger timers, samples the chain's serial output, and reassembles one 33-bit record per timer: an enabled flag plus a 32-bit timestamp. Each record is presented on a valid/ready port to the host-side logic. Sits between the timer array and the USB/UART report formatter.

## Interface

Parameters:
- `NUM_TIMERS`, 4: timers in the chain; legal range is 1 or more.
- `HALF_PERIOD`, 8: `clk` cycles per `data_clock` half-period; legal range is 4 or more (timers use a 2-flop synchroniser plus an edge detect).
- `IDX_W`, `$clog2(NUM_TIMERS)` with a minimum of 1: width of `word_index`.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle readout request; ignored unless idle.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse after the final record is accepted.
- `data_clock` out 1: serial clock to all timers; registered.
- `data_shiftin` out 1: drives the first timer's `data_shiftin`; constant 0.
- `data_shiftout` in 1: serial output of the last timer in the chain.
- `word_data` out 32: timestamp of the current record.
- `word_enabled` out 1: enabled flag of the current record.
- `word_triggered` out 1: high when `word_data != 32'hFFFF_FFFE` (that value is the no-trigger marker).
- `word_index` out IDX_W: record number; 0 is the timer nearest the reader.
- `word_valid` out 1: record valid.
- `word_ready` in 1: consumer accepts the record when `word_valid && word_ready`.

## Operation

- States: IDLE, LOW, HIGH, PRESENT.
- **IDLE**
  - `data_clock`=0.
  - On `start`=1, clear the bit counter (0..32) and the word counter, then go to LOW.
- **LOW**
  - `data_clock`=0 for `HALF_PERIOD` cycles.
  - On the last cycle, shift the sample in: `sr <= {data_shiftout, sr[32:1]}`.
  - If the bit counter is 32, go to PRESENT. Otherwise increment the bit counter and go to HIGH.
- **HIGH**
  - `data_clock`=1 for `HALF_PERIOD` cycles, then go to LOW.
- **PRESENT**
  - `data_clock` held 0. `word_valid`=1 with `word_enabled=sr[0]`, `word_data=sr[32:1]`, `word_index` = word counter.
  - Outputs stay stable until accepted; the stall length is unbounded.
  - On accept:
    - Last word (counter = `NUM_TIMERS-1`): pulse `done`, go to IDLE.
    - Otherwise: increment the word counter, clear the bit counter, go to HIGH.
- Bit order per timer is LSB-first: bit 0 = enabled flag, bits 1..32 = data[0]..data[31].
- The first bit is sampled before any rising edge. No rising edge follows the final bit of the last record.
- Total rising edges per readout: `33*NUM_TIMERS - 1`.
- Reset (`reset`=0 at a clock edge) outputs:
  - `data_clock`=0, `busy`=0, `done`=0, `word_valid`=0.
  - `word_data`=0, `word_enabled`=0, `word_index`=0, state IDLE.
- Reset mid-readout: the same values apply at the next edge and the partial record is discarded. The timers must be re-armed before the next readout.
- `start` while busy is ignored, with no queuing.
- `word_ready` outside PRESENT is ignored.

## Timing

- `start` is accepted at cycle t. LOW for bit 0 occupies cycles t+1..t+H, where H = `HALF_PERIOD`.
- First `word_valid` rises at t+65H+1.
- With `word_ready` tied high, each further record takes 66H+1 cycles: a 1-cycle PRESENT, an H-cycle inter-word HIGH, 33 LOW phases and 32 intra-word HIGH phases.
- `done` is asserted the cycle after the final accept. `busy` falls in the same cycle as `done`.
- Sampling happens 2H-1 cycles after the preceding rising edge, so timer shift latency of 3 cycles or less is always covered.
- `data_clock` is glitch-free: it only changes on a phase boundary, from a register.

## Test plan

- **Single timer, triggered.** `NUM_TIMERS`=1, H=4, one timer model triggered with data 32'h1234_5678 and enabled=1. Send `start` with `word_ready`=1. Require one record {1, 32'h1234_5678, index 0, triggered=1} at t+261, `done` at t+262, and exactly 32 `data_clock` rising edges.
- **Three timers, mixed.** Timer 0 (first in chain) = 32'hA, timer 1 = untriggered, timer 2 = 32'hDEAD_BEEF. Require records in order:
  - index 0 = 32'hDEAD_BEEF;
  - index 1 = 32'hFFFF_FFFE with triggered=0;
  - index 2 = 32'hA.
  Require 98 rising edges.
- **Backpressure.** Hold `word_ready`=0 for 50 cycles on each record. Require `word_valid` and the record held stable, `data_clock` low throughout the stall, and data identical to the no-stall run.
- **Reset mid-readout.** Drop `reset` during HIGH of bit 17 of record 1. Require all outputs at their reset values on the next cycle and no `done`. Re-arm the timers, send `start` again, and require a correct full readout.
- **Ignored start.** Pulse `start` while busy and require no restart and an unchanged edge count. Then verify that H=4 versus H=16 scales the first-valid latency to 4·65+1 and 16·65+1.
